code_entry_frontend: RTL and testbench

Operator-side front end that drives the combination-lock FSM's `enter` and `correct_digit` inputs.
- Synchronizes and debounces the raw ENTER push-button.
- Samples the digit switches and compares them against the stored code digit selected by the lock's current state.
- Emits a one-cycle `enter` pulse with `correct_digit` valid in the same cycle.
- Enforces a lockout period after repeated wrong digits.

---
 rtl/lock_pkg.sv | 15 +
 rtl/btn_debounce.sv | 44 ++++
 rtl/code_entry_frontend.sv | 135 +++++++++++++
 tb/tb_code_entry_frontend.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared lock state encodings and front-end FSM state type
package lock_pkg;

  localparam logic [1:0] S0 = 2'd0;
  localparam logic [1:0] S1 = 2'd1;
  localparam logic [1:0] S2 = 2'd2;
  localparam logic [1:0] S3 = 2'd3;

  localparam int DIGIT_W = 4;

  typedef logic [0:0] fe_state_t;
  localparam fe_state_t FE_IDLE    = 1'b0;
  localparam fe_state_t FE_LOCKOUT = 1'b1;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchronizer, stability counter and rising-edge press pulse
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1;
  logic          btn_s;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1   <= 1'b0;
      btn_s   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= btn;
      btn_s   <= sync1;
      level_d <= level;
      // any agreeing cycle restarts the stability window
      if (btn_s == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = level & ~level_d;

endmodule

// File: rtl/code_entry_frontend.sv
// rtl/code_entry_frontend.sv - debounced ENTER, digit compare and lockout; PROG_CODE_EN makes the code programmable
module code_entry_frontend
  import lock_pkg::*;
#(
  parameter int                 DEBOUNCE_CYCLES = 250000,
  parameter logic [DIGIT_W-1:0] CODE0           = 4'h1,
  parameter logic [DIGIT_W-1:0] CODE1           = 4'h2,
  parameter logic [DIGIT_W-1:0] CODE2           = 4'h3,
  parameter int                 MAX_FAILS       = 3,
  parameter int                 LOCKOUT_CYCLES  = 25000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_enter,
  input  logic [DIGIT_W-1:0] digit_sw,
  input  logic [1:0]         lock_state,
  input  logic               prog,
  output logic               enter,
  output logic               correct_digit,
  output logic               lockout,
  output logic [3:0]         fail_count
);

  localparam int LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  logic               press;
  logic               prog_take;
  logic [DIGIT_W-1:0] code_sel;
  logic               digit_ok;
  logic [3:0]         fail_next;
  fe_state_t          state;
  logic [LW-1:0]      lock_cnt;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk  (clk),
    .reset(reset),
    .btn  (btn_enter),
    .press(press)
  );

`ifdef PROG_CODE_EN
  logic [DIGIT_W-1:0] code [3];
  logic               prog_active;
  logic [1:0]         prog_idx;

  // programming presses are consumed here and never reach the lock
  assign prog_take = press && (state == FE_IDLE) && prog && (prog_active || (lock_state == S3));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      code[0]     <= CODE0;
      code[1]     <= CODE1;
      code[2]     <= CODE2;
      prog_active <= 1'b0;
      prog_idx    <= 2'd0;
    end else if (prog_active && !prog) begin
      prog_active <= 1'b0;
    end else if (prog_take) begin
      if (prog_active) begin
        code[prog_idx] <= digit_sw;
        prog_idx       <= prog_idx + 2'd1;
        if (prog_idx == 2'd2) prog_active <= 1'b0;
      end else begin
        prog_active <= 1'b1;
        prog_idx    <= 2'd0;
      end
    end
  end

  always_comb begin
    code_sel = code[2];
    case (lock_state)
      S0:      code_sel = code[0];
      S1:      code_sel = code[1];
      default: code_sel = code[2];
    endcase
  end
`else
  logic unused_prog;
  assign unused_prog = prog;
  assign prog_take   = 1'b0;

  always_comb begin
    code_sel = CODE2;
    case (lock_state)
      S0:      code_sel = CODE0;
      S1:      code_sel = CODE1;
      default: code_sel = CODE2;
    endcase
  end
`endif

  assign digit_ok  = (lock_state != S3) && (digit_sw == code_sel);
  assign fail_next = fail_count + 4'd1;
  assign lockout   = (state == FE_LOCKOUT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= FE_IDLE;
      lock_cnt      <= '0;
      fail_count    <= 4'd0;
      enter         <= 1'b0;
      correct_digit <= 1'b0;
    end else begin
      enter         <= 1'b0;
      correct_digit <= 1'b0;
      if (state == FE_IDLE) begin
        if (press && !prog_take) begin
          enter         <= 1'b1;
          correct_digit <= digit_ok;
          if ((lock_state != S3) && !digit_ok) begin
            fail_count <= fail_next;
            if (fail_next == 4'(MAX_FAILS)) begin
              state    <= FE_LOCKOUT;
              lock_cnt <= LW'(LOCKOUT_CYCLES - 1);
            end
          end
        end
      end else begin
        // presses in lockout, including the exit cycle, are dropped
        if (lock_cnt == '0) begin
          state      <= FE_IDLE;
          fail_count <= 4'd0;
        end else begin
          lock_cnt <= lock_cnt - 1'b1;
        end
      end
      // lock in S3 means the code was just accepted
      if (lock_state == S3) fail_count <= 4'd0;
    end
  end

endmodule

// File: tb/tb_code_entry_frontend.sv
// tb/tb_code_entry_frontend.sv - scoreboard bench for code_entry_frontend with a press-level reference model
module tb_code_entry_frontend;

  localparam int DB = 4;
  localparam int LK = 10;
  localparam int MF = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_enter = 1'b0;
  logic [3:0] digit_sw = 4'd0;
  logic [1:0] lock_state = 2'd0;
  logic       prog = 1'b0;
  logic       enter;
  logic       correct_digit;
  logic       lockout;
  logic [3:0] fail_count;

  always #5 clk = ~clk;

  code_entry_frontend #(
    .DEBOUNCE_CYCLES(DB),
    .CODE0          (4'h1),
    .CODE1          (4'h2),
    .CODE2          (4'h3),
    .MAX_FAILS      (MF),
    .LOCKOUT_CYCLES (LK)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_enter    (btn_enter),
    .digit_sw     (digit_sw),
    .lock_state   (lock_state),
    .prog         (prog),
    .enter        (enter),
    .correct_digit(correct_digit),
    .lockout      (lockout),
    .fail_count   (fail_count)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    int at;
    int corr;
    int fails;
  } exp_t;
  exp_t sbq[$];

  // reference model: one entry per debounced press, in the operator's terms
  int m_fails = 0;
  int m_code[3] = '{1, 2, 3};
  int lk_start = -1;
  int lk_end = -1;
  bit m_prog_mode = 0;
  int m_prog_idx = 0;

  task automatic model_reset();
    m_fails     = 0;
    m_code      = '{1, 2, 3};
    m_prog_mode = 0;
    m_prog_idx  = 0;
    lk_end      = cyc;
    sbq.delete();
  endtask

  task automatic model_press(input int r, input int d, input int ls, input bit pg);
    int e;
    int corr;
    e = r + DB + 3;
    if (e > lk_start && e <= lk_end) return;
    if (m_fails >= MF) m_fails = 0;
    if (m_prog_mode && pg) begin
      m_code[m_prog_idx] = d;
      m_prog_idx++;
      if (m_prog_idx == 3) m_prog_mode = 0;
      return;
    end
    if (pg && ls == 3) begin
      m_prog_mode = 1;
      m_prog_idx  = 0;
      return;
    end
    corr = (ls != 3 && d == m_code[ls]) ? 1 : 0;
    if (ls == 3) begin
      m_fails = 0;
    end else if (corr == 0) begin
      m_fails++;
      if (m_fails == MF) begin
        lk_start = e;
        lk_end   = e + LK;
      end
    end
    sbq.push_back('{e, corr, m_fails});
  endtask

  // hold < 0 leaves the button pressed and returns at once
  task automatic press(input int d, input int ls, input int hold, input int gap, input bit bounce);
    @(negedge clk);
    digit_sw   = 4'(d);
    lock_state = 2'(ls);
    if (ls == 3) m_fails = 0;
    if (bounce) begin
      btn_enter = 1'b1; @(negedge clk);
      btn_enter = 1'b0; @(negedge clk);
      btn_enter = 1'b1; @(negedge clk);
      btn_enter = 1'b0; @(negedge clk);
    end
    btn_enter = 1'b1;
    model_press(cyc, d, ls, prog);
    if (hold < 0) return;
    repeat (hold) @(negedge clk);
    btn_enter = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  always begin
    exp_t x;
    @(negedge clk);
    #1;
    chk("lockout", int'(lockout), (cyc >= lk_start && cyc < lk_end) ? 1 : 0);
    if (enter) begin
      chk("enter_expected", (sbq.size() > 0) ? 1 : 0, 1);
      if (sbq.size() > 0) begin
        x = sbq.pop_front();
        chk("enter_cycle", cyc, x.at);
        chk("correct_digit", int'(correct_digit), x.corr);
        chk("fail_count", int'(fail_count), x.fails);
      end
    end else begin
      chk("correct_idle", int'(correct_digit), 0);
    end
  end

  initial begin
    int ls, d;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    chk("rst_enter", int'(enter), 0);
    chk("rst_correct", int'(correct_digit), 0);
    chk("rst_lockout", int'(lockout), 0);
    chk("rst_fail_count", int'(fail_count), 0);

    press(1, 0, 8, 6, 0);
    press(1, 0, 20, 6, 1);

    press(9, 1, 6, 6, 0);
    press(9, 1, 6, 6, 0);
    press(9, 1, 4, 4, 0);
    press(9, 1, -1, 0, 0);
    while (cyc < lk_end - 1) @(negedge clk);
    #1;
    chk("lock_last_cycle", int'(lockout), 1);
    chk("lock_last_fails", int'(fail_count), MF);
    @(negedge clk);
    #1;
    chk("lock_exit_fails", int'(fail_count), 0);
    btn_enter = 1'b0;
    repeat (6) @(negedge clk);

    press(9, 0, 6, 6, 0);
    press(9, 2, 6, 6, 0);
    @(negedge clk);
    lock_state = 2'd3;
    m_fails = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("s3_clears_fails", int'(fail_count), 0);
    press(5, 3, 6, 6, 0);

    press(0, 1, 6, 6, 0);
    press(0, 1, 6, 6, 0);
    press(0, 1, 4, 4, 0);
    press(1, 0, -1, 0, 0);
    repeat (2) @(negedge clk);
    chk("in_lockout_before_reset", int'(lockout), 1);
    model_reset();
    reset = 1'b1;
    #1;
    chk("midrst_enter", int'(enter), 0);
    chk("midrst_correct", int'(correct_digit), 0);
    chk("midrst_lockout", int'(lockout), 0);
    chk("midrst_fail_count", int'(fail_count), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_press(cyc, 1, 0, prog);
    repeat (12) @(negedge clk);
    btn_enter = 1'b0;
    repeat (6) @(negedge clk);

`ifdef PROG_CODE_EN
    prog = 1'b1;
    press(0, 3, 6, 6, 0);
    press(7, 3, 6, 6, 0);
    press(8, 3, 6, 6, 0);
    press(9, 3, 6, 6, 0);
    @(negedge clk);
    prog = 1'b0;
    m_prog_mode = 0;
    press(7, 0, 6, 6, 0);
    press(1, 0, 6, 6, 0);
`endif

    for (int i = 0; i < 30; i++) begin
      ls = $urandom_range(0, 3);
      d  = ($urandom_range(0, 1) == 1) ? m_code[(ls < 3) ? ls : 0] : $urandom_range(0, 15);
      press(d, ls, $urandom_range(4, 10), $urandom_range(4, 10), ($urandom_range(0, 3) == 0));
    end

    repeat (20) @(negedge clk);
    chk("sb_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
